// File: rtl/ser_pkg.sv
// Shared types and constants for the FIFO byte serializer.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } ser_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/fifo_byte_serializer.sv
// Drains DATA_WIDTH-bit FIFO words into a valid/ready byte stream; first byte 2 cycles after pop request, one bubble per word.
// Bytes are held until accepted; optional even-parity output under SER_PARITY_EN.
module fifo_byte_serializer
  import ser_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [BYTE_W-1:0]     byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready,
`ifdef SER_PARITY_EN
  output logic                  byte_parity,
`endif
  output logic                  busy
);

  localparam int NBYTES = DATA_WIDTH / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  ser_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_valid;

  logic                  w_last;
  logic                  w_pop;
  logic [IDX_W-1:0]      w_sel;
  logic [BYTE_W-1:0]     w_bytes [NBYTES];

  for (genvar g = 0; g < NBYTES; g++) begin : g_bytes
    assign w_bytes[g] = r_shift[g*BYTE_W +: BYTE_W];
  end

  assign w_last = (r_idx == LAST_IDX);
  assign w_sel  = MSB_FIRST ? (LAST_IDX - r_idx) : r_idx;

  // Qualified by rst so no pop can leak out while the block is held in reset.
  assign w_pop = rst && en && !fifo_empty &&
                 ((r_state == IDLE) ||
                  ((r_state == SEND) && byte_ready && w_last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) r_state <= WAIT;
        end
        WAIT: begin
          r_shift <= fifo_dout;
          r_idx   <= '0;
          r_valid <= 1'b1;
          r_state <= SEND;
        end
        SEND: begin
          if (byte_ready) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_state <= w_pop ? WAIT : IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en = w_pop;
  assign byte_valid = r_valid;
  assign byte_data  = w_bytes[w_sel];
  assign busy       = (r_state != IDLE);

`ifdef SER_PARITY_EN
  assign byte_parity = ^byte_data;
`endif

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench: two serializers (MSB-first and LSB-first) each fed by a small behavioural FIFO.
module tb_fifo_byte_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  // ---- DUT0: MSB first ----
  logic        en0 = 1'b0, ready0 = 1'b0;
  logic        empty0, rd_en0, valid0, busy0;
  logic [31:0] dout0 = '0;
  logic [7:0]  data0;
  // ---- DUT1: LSB first ----
  logic        en1 = 1'b0, ready1 = 1'b0;
  logic        empty1, rd_en1, valid1, busy1;
  logic [31:0] dout1 = '0;
  logic [7:0]  data1;
`ifdef SER_PARITY_EN
  logic        par0, par1;
`endif

  fifo_byte_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .en(en0), .fifo_empty(empty0), .fifo_dout(dout0),
    .fifo_rd_en(rd_en0), .byte_data(data0), .byte_valid(valid0), .byte_ready(ready0),
`ifdef SER_PARITY_EN
    .byte_parity(par0),
`endif
    .busy(busy0));

  fifo_byte_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_rd_en(rd_en1), .byte_data(data1), .byte_valid(valid1), .byte_ready(ready1),
`ifdef SER_PARITY_EN
    .byte_parity(par1),
`endif
    .busy(busy1));

  // Behavioural FIFOs: bench writes via wp, popping advances rp on rd_en.
  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
  int npop0 = 0, npop1 = 0, viol = 0, cyc = 0;
  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);

  logic [7:0] got0 [64];
  int         hcyc0 [64];
  int         ng0 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en0) begin
      dout0 <= mem0[rp0 % 16];
      rp0   <= rp0 + 1;
      npop0 <= npop0 + 1;
    end
    if (rd_en1) begin
      dout1 <= mem1[rp1 % 16];
      rp1   <= rp1 + 1;
      npop1 <= npop1 + 1;
    end
    if ((rd_en0 && empty0) || (rd_en1 && empty1)) viol <= viol + 1;
    if (valid0 && ready0) begin
      got0[ng0 % 64]  <= data0;
      hcyc0[ng0 % 64] <= cyc;
      ng0             <= ng0 + 1;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic push0(input logic [31:0] w);
    mem0[wp0 % 16] = w;
    wp0 = wp0 + 1;
  endtask

  initial begin
    int base, pbase;
    logic [31:0] exp4 [12];
    logic [7:0]  bexp;

    // Reset state
    step(1);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_rd_en", rd_en0, 1'b0);
    chk("rst_data", data0, 8'h00);

    // Single word, MSB first, sink always ready
    rst = 1'b1;
    step(1);
    en0 = 1'b1; ready0 = 1'b1;
    base = ng0; pbase = npop0;
    push0(32'hA1B2C3D4);
    step(1);
    chk("t2_wait_valid", valid0, 1'b0);
    chk("t2_wait_busy", busy0, 1'b1);
    step(1);
    chk("t2_first_valid", valid0, 1'b1);
    chk("t2_first_data", data0, 8'hA1);
    step(6);
    chk("t2_nbytes", ng0 - base, 4);
    chk("t2_b0", got0[base],   8'hA1);
    chk("t2_b1", got0[base+1], 8'hB2);
    chk("t2_b2", got0[base+2], 8'hC3);
    chk("t2_b3", got0[base+3], 8'hD4);
    chk("t2_pops", npop0 - pbase, 1);
    chk("t2_idle", busy0, 1'b0);

    // LSB first with ready toggling; data held while not ready
    en1 = 1'b1; ready1 = 1'b0;
    mem1[wp1 % 16] = 32'hA1B2C3D4; wp1 = wp1 + 1;
    step(1);
    chk("t3_wait_valid", valid1, 1'b0);
    step(1);
    chk("t3_b0", data1, 8'hD4);
    chk("t3_b0_valid", valid1, 1'b1);
    step(1);
    chk("t3_b0_held", data1, 8'hD4);
    chk("t3_valid_held", valid1, 1'b1);
    ready1 = 1'b1;
    step(1);
    chk("t3_b1", data1, 8'hC3);
    ready1 = 1'b0;
    step(1);
    chk("t3_b1_held", data1, 8'hC3);
    ready1 = 1'b1;
    step(1);
    chk("t3_b2", data1, 8'hB2);
    step(1);
    chk("t3_b3", data1, 8'hA1);
    step(1);
    chk("t3_done_valid", valid1, 1'b0);
    chk("t3_done_busy", busy1, 1'b0);
    chk("t3_pops", npop1, 1);

    // Three queued words, back to back
    base = ng0; pbase = npop0;
    push0(32'h01020304); push0(32'h05060708); push0(32'h090A0B0C);
    step(20);
    chk("t4_nbytes", ng0 - base, 12);
    chk("t4_pops", npop0 - pbase, 3);
    chk("t4_span", hcyc0[base+11] - hcyc0[base], 13);
    for (int i = 0; i < 12; i++) begin
      exp4[i] = 32'(i + 1);
      chk($sformatf("t4_b%0d", i), got0[base+i], exp4[i]);
    end

    // en dropped mid-word
    base = ng0; pbase = npop0;
    push0(32'h11223344); push0(32'h55667788);
    step(4);
    chk("t5_third_byte", data0, 8'h33);
    en0 = 1'b0;
    step(6);
    chk("t5_nbytes", ng0 - base, 4);
    chk("t5_b2", got0[base+2], 8'h33);
    chk("t5_b3", got0[base+3], 8'h44);
    chk("t5_pops", npop0 - pbase, 1);
    chk("t5_idle", busy0, 1'b0);
    chk("t5_no_rd_en", rd_en0, 1'b0);
    en0 = 1'b1;
    step(7);
    chk("t5_resume_nbytes", ng0 - base, 8);
    chk("t5_resume_b4", got0[base+4], 8'h55);

    // Reset asserted mid-SEND with another word pending
    base = ng0;
    push0(32'hDEADBEEF);
    step(2);
    chk("t1_sending", data0, 8'hDE);
    ready0 = 1'b0;
    push0(32'hCAFEF00D);
    step(1);
    rst = 1'b0;
    #1;
    chk("t1_rst_valid", valid0, 1'b0);
    chk("t1_rst_busy", busy0, 1'b0);
    chk("t1_rst_rd_en", rd_en0, 1'b0);
    chk("t1_rst_data", data0, 8'h00);
    step(1);
    rst = 1'b1; ready0 = 1'b1;
    pbase = npop0;
    step(8);
    chk("t1_nbytes", ng0 - base, 4);
    chk("t1_b0", got0[base],   8'hCA);
    chk("t1_b3", got0[base+3], 8'h0D);
    chk("t1_pops", npop0 - pbase, 1);

`ifdef SER_PARITY_EN
    ready0 = 1'b0;
    push0(32'h07030000);
    step(2);
    bexp = 8'h07;
    chk("t6_data07", data0, bexp);
    chk("t6_par07", par0, 1'b1);
    ready0 = 1'b1;
    step(1);
    chk("t6_par03", par0, 1'b0);
    step(5);
`endif

    chk("t6_no_pop_when_empty", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
